// File: rtl/lq_pkg.sv
// lq_pkg: shared load-queue opcodes, FSM states, access-width encoding and opcode decode.
package lq_pkg;
  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } lq_op_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} lq_state_e;
  localparam logic [2:0] W_B = 3'b001;
  localparam logic [2:0] W_H = 3'b010;
  localparam logic [2:0] W_W = 3'b100;
  // Returns {width, signed}; unknown opcodes fall back to an unsigned word.
  function automatic logic [3:0] op_decode(input logic [2:0] op);
    return (op == OP_LB)  ? {W_B, 1'b1} :
           (op == OP_LH)  ? {W_H, 1'b1} :
           (op == OP_LBU) ? {W_B, 1'b0} :
           (op == OP_LHU) ? {W_H, 1'b0} : {W_W, 1'b0};
  endfunction
endpackage

// File: rtl/lq_oldest_select.sv
// lq_oldest_select: picks the oldest entry of a mask using an age matrix.
// Ports: mask_i candidate entries; age_i[j][i] set when entry j is older than entry i;
// found_o any candidate; idx_o index of the candidate no other candidate is older than.
module lq_oldest_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]             mask_i,
  input  logic [DEPTH-1:0][DEPTH-1:0]  age_i,
  output logic                         found_o,
  output logic [$clog2(DEPTH)-1:0]     idx_o
);
  localparam int IW = $clog2(DEPTH);
  logic blocked;
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) blocked = blocked | (mask_i[j] & age_i[j][i]);
      if (mask_i[i] && !blocked && !found_o) begin
        found_o = 1'b1;
        idx_o = i[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/load_queue.sv
// load_queue: age-ordered load queue issuing committed loads to memory one at a time.
// Ports: clk_in/rst_n_in clock and async active-low reset; rdy_in global enable;
// flush_in misprediction flush; alloc_* new load in, alloc_rdy_out space available;
// ack_* entry index back to the ROB; commit_* entry safe to load; mem_* memory
// request/response; wb_* writeback of the loaded data.
module load_queue
  import lq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int ROBW  = 4,
  parameter int DW    = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     alloc_en_in,
  input  logic [AW-1:0]            alloc_addr_in,
  input  logic [ROBW-1:0]          alloc_dest_in,
  input  logic [2:0]               alloc_op_in,
  output logic                     alloc_rdy_out,
  output logic                     ack_en_out,
  output logic [ROBW-1:0]          ack_dest_out,
  output logic [$clog2(DEPTH)-1:0] ack_idx_out,
  input  logic                     commit_en_in,
  input  logic [$clog2(DEPTH)-1:0] commit_idx_in,
  output logic                     mem_req_out,
  output logic [AW-1:0]            mem_addr_out,
  output logic [2:0]               mem_width_out,
  output logic                     mem_sgn_out,
  input  logic                     mem_done_in,
  input  logic [DW-1:0]            mem_data_in,
  output logic                     wb_en_out,
  output logic [ROBW-1:0]          wb_dest_out,
  output logic [DW-1:0]            wb_data_out
);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d, lo_age;
  logic [AW-1:0] addr_q [DEPTH];
  logic [ROBW-1:0] dest_q [DEPTH];
  logic [2:0] op_q [DEPTH];
  lq_state_e state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, old_idx, free_idx;
  logic old_found, free_found, issue, alloc_fire, wb_fire, dec_sgn;
  logic [2:0] dec_width;
  logic alloc_rdy_q, ack_en_q, mem_req_q, mem_sgn_q, wb_en_q;
  logic [ROBW-1:0] ack_dest_q, wb_dest_q;
  logic [IW-1:0] ack_idx_q;
  logic [AW-1:0] mem_addr_q;
  logic [2:0] mem_width_q;
  logic [DW-1:0] wb_data_q;
  // Fixed "lower index is older" matrix turns the oldest-select into a lowest-index pick.
  always_comb begin
    lo_age = '0;
    for (int j = 0; j < DEPTH; j++)
      for (int i = 0; i < DEPTH; i++) lo_age[j][i] = (j < i);
  end
  lq_oldest_select #(.DEPTH(DEPTH)) u_oldest (
    .mask_i (valid_q & ready_q),
    .age_i  (age_q),
    .found_o(old_found),
    .idx_o  (old_idx)
  );
  lq_oldest_select #(.DEPTH(DEPTH)) u_free (
    .mask_i (~valid_q),
    .age_i  (lo_age),
    .found_o(free_found),
    .idx_o  (free_idx)
  );
  assign {dec_width, dec_sgn} = op_decode(op_q[old_idx]);
  assign issue = (state_q == S_IDLE) && old_found && !flush_in;
  assign alloc_fire = alloc_en_in && alloc_rdy_q && free_found && !flush_in;
  assign wb_fire = (state_q == S_WAIT) && mem_done_in && !flush_in;
  // A new entry is younger than every live entry; a freed entry drops out of the matrix.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    age_d = age_q;
    if (alloc_fire) begin
      valid_d[free_idx] = 1'b1;
      ready_d[free_idx] = 1'b0;
      age_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = valid_q[j];
    end
    if (commit_en_in && valid_q[commit_idx_in]) ready_d[commit_idx_in] = 1'b1;
    if (wb_fire) begin
      valid_d[sel_q] = 1'b0;
      ready_d[sel_q] = 1'b0;
      age_d[sel_q] = '0;
      for (int j = 0; j < DEPTH; j++) age_d[j][sel_q] = 1'b0;
    end
    if (flush_in) begin
      valid_d = '0;
      ready_d = '0;
      age_d = '0;
    end
  end
  // A response coinciding with a flush in WAIT closes the access; waiting in DRAIN would hang.
  always_comb begin
    state_d = state_q;
    sel_d = issue ? old_idx : sel_q;
    case (state_q)
      S_IDLE:  state_d = issue ? S_REQ : S_IDLE;
      S_REQ:   state_d = flush_in ? S_DRAIN : S_WAIT;
      S_WAIT:  state_d = mem_done_in ? S_IDLE : flush_in ? S_DRAIN : S_WAIT;
      S_DRAIN: state_d = mem_done_in ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      ready_q <= '0;
      age_q <= '0;
      state_q <= S_IDLE;
      sel_q <= '0;
      alloc_rdy_q <= 1'b1;
      ack_en_q <= 1'b0;
      ack_dest_q <= '0;
      ack_idx_q <= '0;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
      mem_width_q <= '0;
      mem_sgn_q <= 1'b0;
      wb_en_q <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else if (rdy_in) begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      age_q <= age_d;
      state_q <= state_d;
      sel_q <= sel_d;
      alloc_rdy_q <= ~&valid_d;
      ack_en_q <= alloc_fire;
      ack_dest_q <= alloc_fire ? alloc_dest_in : ack_dest_q;
      ack_idx_q <= alloc_fire ? free_idx : ack_idx_q;
      mem_req_q <= issue;
      mem_addr_q <= issue ? addr_q[old_idx] : mem_addr_q;
      mem_width_q <= issue ? dec_width : mem_width_q;
      mem_sgn_q <= issue ? dec_sgn : mem_sgn_q;
      wb_en_q <= wb_fire;
      wb_dest_q <= wb_fire ? dest_q[sel_q] : wb_dest_q;
      wb_data_q <= wb_fire ? mem_data_in : wb_data_q;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rdy_in && alloc_fire) begin
      addr_q[free_idx] <= alloc_addr_in;
      dest_q[free_idx] <= alloc_dest_in;
      op_q[free_idx] <= alloc_op_in;
    end
  end
  assign alloc_rdy_out = alloc_rdy_q;
  assign ack_en_out = ack_en_q;
  assign ack_dest_out = ack_dest_q;
  assign ack_idx_out = ack_idx_q;
  assign mem_req_out = mem_req_q;
  assign mem_addr_out = mem_addr_q;
  assign mem_width_out = mem_width_q;
  assign mem_sgn_out = mem_sgn_q;
  assign wb_en_out = wb_en_q;
  assign wb_dest_out = wb_dest_q;
  assign wb_data_out = wb_data_q;
endmodule

// File: doc/load_queue.md
LOAD_QUEUE -- requirements
Module: load_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (power of 2, 2..32).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter ROBW, default 4, meaning ROB tag width.
REQ-004 SHALL have parameter DW, default 32, meaning result data width.
REQ-005 SHALL have port clk_in  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n_in  input  1  meaning reset; asynchronous, active-low.
REQ-007 SHALL have port rdy_in  input  1  meaning global enable; when low, all state holds.
REQ-008 SHALL have port flush_in  input  1  meaning ROB misprediction flush.
REQ-009 SHALL have ports alloc_en_in (input, 1), alloc_addr_in (input, AW), alloc_dest_in (input, ROBW) and alloc_op_in (input, 3), meaning a new load from the address unit.
REQ-010 SHALL have port alloc_rdy_out  output  1  meaning at least one free entry.
REQ-011 SHALL have ports ack_en_out (output, 1), ack_dest_out (output, ROBW) and ack_idx_out (output, log2 DEPTH), meaning the entry index reported to the ROB.
REQ-012 SHALL have ports commit_en_in (input, 1) and commit_idx_in (input, log2 DEPTH), meaning the ROB marks the entry safe to load.
REQ-013 SHALL have ports mem_req_out (output, 1), mem_addr_out (output, AW), mem_width_out (output, 3, one-hot 1/2/4 bytes) and mem_sgn_out (output, 1).
REQ-014 SHALL have ports mem_done_in (input, 1) and mem_data_in (input, DW), meaning the memory response.
REQ-015 SHALL have ports wb_en_out (output, 1), wb_dest_out (output, ROBW) and wb_data_out (output, DW), meaning the CDB/ROB writeback.

Function
REQ-016 SHALL accept an allocation only when alloc_en_in && alloc_rdy_out; the entry index is the lowest free index; the entry becomes valid, not ready.
REQ-017 SHALL pulse ack_en_out one cycle after allocation, with ack_dest_out and ack_idx_out of that entry.
REQ-018 SHALL set ready on the entry indicated by commit_en_in at the next edge; commit to an invalid entry is ignored.
REQ-019 SHALL issue the oldest (allocation order) valid ready entry; the age matrix is updated on allocation and on free.
REQ-020 SHALL implement FSM IDLE -> REQ (entry selected) -> WAIT -> IDLE (mem_done_in); a flush in REQ or WAIT -> DRAIN -> IDLE (mem_done_in).
REQ-021 SHALL hold mem_req_out high in REQ for exactly one cycle, with address, width and sign from the entry: LB 000 -> 001/1; LH 001 -> 010/1; LW 010 -> 100/0; LBU 100 -> 001/0; LHU 101 -> 010/0; other opcodes are treated as LW.
REQ-022 SHALL, on mem_done_in in WAIT, register wb_en_out=1, wb_dest_out and wb_data_out for one cycle and free the entry on the same edge.
REQ-023 SHALL, on the same edge as mem_done_in, allow the freed index to be reallocated starting the following cycle; alloc_rdy_out is registered from the free count.
REQ-024 SHALL, on flush_in, invalidate all entries, clear the age matrix, and suppress ack and wb on the next cycle; allocation and commit on a flush cycle are ignored.
REQ-025 SHALL, in DRAIN, discard mem_data_in and not assert wb_en_out; no new request is issued until IDLE.
REQ-026 SHALL give minimum latency from commit to mem_req_out of 2 cycles (commit edge, select-to-REQ edge).

Reset
REQ-027 SHALL, on rst_n_in low, asynchronously clear all valid/ready bits, the age matrix and the FSM (to IDLE), and drive mem_req_out, ack_en_out and wb_en_out to 0, alloc_rdy_out to 1, and data/address outputs to 0.

Structure
REQ-028 SHALL place the opcode constants (LB/LH/LW/LBU/LHU), FSM state encodings and the width encoding in shared package lq_pkg.
REQ-029 SHALL use one sub-module, lq_oldest_select (combinational, DEPTH-parametrised age-matrix oldest-of-mask), instantiated twice: oldest-ready selection and lowest-free selection by mask.

Verification
REQ-030 SHALL cover this scenario: reset; allocate 3 loads (dest 1,2,3); commit idx 2 then 0 in the same cycle order -> idx 0 (dest 1) issues first after both are ready.
REQ-031 SHALL cover this scenario: fill DEPTH=8 -> alloc_rdy_out=0 after the 8th; mem_done_in on one -> alloc_rdy_out=1 the next cycle; a 9th alloc is accepted.
REQ-032 SHALL cover this scenario: LB to 0x100, mem_data_in=0xFFFFFF80 -> mem_width_out=001, mem_sgn_out=1, wb_data_out=0xFFFFFF80, wb_en_out for 1 cycle.
REQ-033 SHALL cover this scenario: flush_in during WAIT, mem_done_in 3 cycles later -> no wb_en_out, FSM IDLE, alloc_rdy_out=1, all entries empty.
REQ-034 SHALL cover this scenario: rdy_in=0 for 5 cycles during WAIT with mem_done_in low -> no state change.
REQ-035 SHALL cover this scenario: rst_n_in asserted mid-WAIT asynchronously -> outputs 0 before the next clock edge.
